nios2_qsys_oci_dct_trace_buffer: RTL and testbench
==================================================

// Module: nios2_qsys_oci_dct_trace_buffer
// PURPOSE
//  Parametrised capture buffer for the Nios II OCI data-capture-trace (DCT) stream.
//  - Accepts DCT words (dct_buffer + dct_count) while armed and stores them in a circular buffer.
//  - Drains them to a valid/ready reader for bench or JTAG upload.
//  - Tracks the test_ending / test_has_ended handshake to flush the buffer and signal completion.
//  - Sits beside the OCI block, replacing the passive DCT test-bench stub in simulation and debug builds.
// PARAMETERS
//  DATA_W     30  width of dct_buffer / rd_data
//  CNT_W      4   width of dct_count / rd_count
//  DEPTH      16  buffer entries; power of two, >= 2
//  WRAP_MODE  0   0: drop new words when full; 1: overwrite oldest entry when full
//  OVF_W      16  width of the saturating overflow counter
// PORTS
//  clk            in   1                    system clock; all logic on the rising edge
//  reset          in   1                    synchronous, active-high reset
//  arm            in   1                    pulse: start a capture session (IDLE/ENDED -> CAPTURE)
//  dct_valid      in   1                    dct_buffer/dct_count qualify this cycle
//  dct_buffer     in   DATA_W               captured trace word
//  dct_count      in   CNT_W                number of valid fields in the word; 0 = empty packet
//  test_ending    in   1                    software is ending the test; stop accepting words
//  test_has_ended in   1                    test finished; completion allowed once drained
//  rd_data        out  DATA_W               oldest stored word (first-word fall-through)
//  rd_count       out  CNT_W                dct_count stored with rd_data
//  rd_valid       out  1                    buffer not empty
//  rd_ready       in   1                    reader accepts the word when rd_valid && rd_ready
//  level          out  $clog2(DEPTH+1)      entries currently stored
//  overflow_cnt   out  OVF_W                dropped or overwritten words; saturates at all-ones
//  state          out  2                    current FSM state encoding
//  done           out  1                    high in ENDED
// BEHAVIOUR
//  - Reset: all outputs are 0; state = IDLE; pointers and level cleared; buffer contents are don't-care.
//  - FSM:
//      IDLE    -(arm)->                                 CAPTURE
//      CAPTURE -(test_ending | test_has_ended)->        FLUSH
//      FLUSH   -(test_has_ended seen && level==0)->     ENDED
//      ENDED   -(arm)->                                 CAPTURE  (overflow_cnt cleared on arm)
//  - test_has_ended is latched in a sticky flag until the next arm or reset.
//  - Encoding: IDLE=0, CAPTURE=1, FLUSH=2, ENDED=3.
//  - Write: accepted only in CAPTURE, with dct_valid=1 and dct_count!=0.
//      - Empty packets and writes in any other state are silently ignored and are not counted.
//  - Latency: a word written in cycle N is visible on rd_data/rd_valid in cycle N+1.
//      - level updates in the same cycle as rd_valid.
//  - Read: a pop occurs on rd_valid && rd_ready in any state, including IDLE and ENDED.
//      - rd_data and rd_count are stable while rd_valid && !rd_ready.
//  - Full, WRAP_MODE=0: the write is dropped and overflow_cnt increments, unless a pop happens in
//    the same cycle. In that case the write is accepted and level is unchanged.
//  - Full, WRAP_MODE=1: the write overwrites the oldest entry, the read pointer advances and
//    overflow_cnt increments.
//      - If a pop happens in the same cycle, the popped word is the pre-overwrite oldest.
//      - Only one advance occurs and overflow_cnt does not increment.
//  - Empty with a simultaneous write and rd_ready: no bypass. The word appears the next cycle.
//  - Pointers wrap modulo DEPTH; level is in the range 0..DEPTH.
//  - overflow_cnt saturates and never wraps.
//  - test_ending and test_has_ended asserted together in CAPTURE: the write in that cycle is still
//    accepted, then the FSM moves to FLUSH.
//  - arm while in CAPTURE or FLUSH: ignored.
//  - reset mid-operation: aborts immediately; stored words are discarded (level = 0).
// STRUCTURE
//  - Shared package nios2_oci_pkg holds:
//      - the state enum / localparams (IDLE, CAPTURE, FLUSH, ENDED);
//      - the DCT_DATA_W=30 and DCT_CNT_W=4 defaults;
//      - the clog2 helper.
//  - Sub-module nios2_oci_trace_fifo: circular storage of (count, data) pairs, read/write pointers,
//    level, and full/empty flags, with an overwrite input.
//  - The top level holds the FSM, the write qualification, the sticky ended flag and overflow_cnt.
// TESTING
//  1. reset, arm, write 3 words (0x1,cnt 2),(0x2,cnt 1),(0x3,cnt 4), rd_ready=1
//     -> rd_data 0x1, 0x2, 0x3 from cycle+1; level returns to 0.
//  2. WRAP_MODE=0, DEPTH=16, write 20 words with no reads
//     -> level=16, overflow_cnt=4, drain yields words 1..16.
//  3. WRAP_MODE=1, same stimulus -> level=16, overflow_cnt=4, drain yields words 5..20.
//  4. Write with dct_count=0, and write while IDLE -> level stays 0, overflow_cnt stays 0.
//  5. 5 words stored, test_ending then test_has_ended, rd_ready held low
//     -> state=FLUSH, done=0; release rd_ready -> 5 pops, then done=1 and state=ENDED.
//  6. Full and simultaneous write + pop (WRAP_MODE=0) -> level stays 16, overflow_cnt unchanged;
//     reset asserted mid-drain -> next cycle rd_valid=0, level=0, state=IDLE.

Source files
------------

// File: rtl/nios2_oci_pkg.sv
// Shared definitions for the Nios II OCI data-capture-trace buffer.
// Holds the FSM encoding, default DCT field widths and a clog2 helper.
package nios2_oci_pkg;

    localparam int DCT_DATA_W = 30;
    localparam int DCT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        ENDED   = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// Circular store of (count, data) pairs with first-word fall-through read.
// When overwrite is set, a write into a full buffer replaces the oldest entry.
module nios2_oci_trace_fifo
    import nios2_oci_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W,
    parameter int CNT_W  = DCT_CNT_W,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [CNT_W-1:0]           wr_count,
    input  logic                       rd_en,
    input  logic                       overwrite,
    output logic [DATA_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           rd_count,
    output logic [clog2(DEPTH+1)-1:0]  level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = clog2(DEPTH + 1);
    localparam int ENT_W = CNT_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             drop;
    logic             push;
    logic             adv;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // A pop on a full buffer frees the slot the write lands in, so the
    // oldest word is read out before the same slot is rewritten.
    assign pop  = rd_en && !empty;
    assign drop = wr_en && overwrite && full && !pop;
    assign push = wr_en && (!full || pop || drop);
    assign adv  = pop || drop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wr_count, wr_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (adv)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, adv})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign {rd_count, rd_data} = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/nios2_qsys_oci_dct_trace_buffer.sv
// Capture buffer for the OCI DCT stream: session FSM, write qualification,
// sticky end-of-test flag and saturating overflow counter around the store.
module nios2_qsys_oci_dct_trace_buffer
    import nios2_oci_pkg::*;
#(
    parameter int DATA_W    = DCT_DATA_W,
    parameter int CNT_W     = DCT_CNT_W,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0,
    parameter int OVF_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       dct_valid,
    input  logic [DATA_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    output logic [DATA_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           rd_count,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [clog2(DEPTH+1)-1:0]  level,
    output logic [OVF_W-1:0]           overflow_cnt,
    output logic [1:0]                 state,
    output logic                       done
);

    state_t st;
    logic   ended_q;
    logic   full;
    logic   empty;
    logic   pop;
    logic   wr_ok;
    logic   lost;
    logic   arm_go;

    assign pop    = rd_ready && !empty;
    assign wr_ok  = (st == CAPTURE) && dct_valid && (dct_count != '0);
    assign lost   = wr_ok && full && !pop;
    assign arm_go = arm && ((st == IDLE) || (st == ENDED));

    assign rd_valid = !empty;
    assign state    = st;

    nios2_oci_trace_fifo #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_ok),
        .wr_data   (dct_buffer),
        .wr_count  (dct_count),
        .rd_en     (rd_ready),
        .overwrite (WRAP_MODE != 0),
        .rd_data   (rd_data),
        .rd_count  (rd_count),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            done         <= 1'b0;
            ended_q      <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (arm_go)              ended_q <= 1'b0;
            else if (test_has_ended) ended_q <= 1'b1;

            // Both drop and overwrite count as lost words.
            if (arm_go)
                overflow_cnt <= '0;
            else if (lost && (overflow_cnt != '1))
                overflow_cnt <= overflow_cnt + 1'b1;

            unique case (st)
                IDLE: begin
                    if (arm) st <= CAPTURE;
                end
                CAPTURE: begin
                    if (test_ending || test_has_ended) st <= FLUSH;
                end
                FLUSH: begin
                    if ((ended_q || test_has_ended) && empty) begin
                        st   <= ENDED;
                        done <= 1'b1;
                    end
                end
                ENDED: begin
                    if (arm) begin
                        st   <= CAPTURE;
                        done <= 1'b0;
                    end
                end
                default: begin
                    st   <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_qsys_oci_dct_trace_buffer.sv
// Bench: a drop-mode and an overwrite-mode instance driven in parallel,
// checked against a queue-based model of the capture session.
module tb_nios2_qsys_oci_dct_trace_buffer;

    localparam int DW    = 30;
    localparam int CW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          dct_valid;
    logic [DW-1:0] dct_buffer;
    logic [CW-1:0] dct_count;
    logic          test_ending;
    logic          test_has_ended;
    logic          rd_ready;

    logic [DW-1:0] rdata  [2];
    logic [CW-1:0] rcnt   [2];
    logic          rvalid [2];
    logic [4:0]    lvl    [2];
    logic [1:0]    st     [2];
    logic          dn     [2];
    logic [15:0]   ovf0;
    logic [2:0]    ovf1;

    logic [33:0]   q [2][$];
    int unsigned   ovf_m [2];
    int            st_m  [2];
    bit            end_m [2];
    int unsigned   ovf_max [2] = '{65535, 7};

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nios2_qsys_oci_dct_trace_buffer #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(0), .OVF_W(16)
    ) dut0 (
        .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_data(rdata[0]), .rd_count(rcnt[0]), .rd_valid(rvalid[0]),
        .rd_ready(rd_ready), .level(lvl[0]), .overflow_cnt(ovf0),
        .state(st[0]), .done(dn[0])
    );

    nios2_qsys_oci_dct_trace_buffer #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(1), .OVF_W(3)
    ) dut1 (
        .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_data(rdata[1]), .rd_count(rcnt[1]), .rd_valid(rvalid[1]),
        .rd_ready(rd_ready), .level(lvl[1]), .overflow_cnt(ovf1),
        .state(st[1]), .done(dn[1])
    );

    function automatic int unsigned ovf_of(int k);
        return (k == 0) ? 32'(ovf0) : 32'(ovf1);
    endfunction

    // Reference behaviour for one clock, from pre-edge inputs and model state.
    task automatic model_step();
        int sz;
        bit pop;
        bit acc;
        bit go;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                q[k].delete();
                ovf_m[k] = 0;
                st_m[k]  = 0;
                end_m[k] = 0;
            end else begin
                sz  = q[k].size();
                pop = rd_ready && (sz > 0);
                acc = (st_m[k] == 1) && dct_valid && (dct_count != 0);
                go  = arm && (st_m[k] == 0 || st_m[k] == 3);
                if (pop) void'(q[k].pop_front());
                if (acc) begin
                    if (sz < DEPTH || pop) begin
                        q[k].push_back({dct_count, dct_buffer});
                    end else begin
                        if (k == 1) begin
                            void'(q[k].pop_front());
                            q[k].push_back({dct_count, dct_buffer});
                        end
                        if (ovf_m[k] < ovf_max[k]) ovf_m[k]++;
                    end
                end
                case (st_m[k])
                    0: if (arm) st_m[k] = 1;
                    1: if (test_ending || test_has_ended) st_m[k] = 2;
                    2: if ((end_m[k] || test_has_ended) && sz == 0) st_m[k] = 3;
                    default: if (arm) st_m[k] = 1;
                endcase
                if (go) begin
                    end_m[k] = 0;
                    ovf_m[k] = 0;
                end else if (test_has_ended) begin
                    end_m[k] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        arm            = 1'b0;
        dct_valid      = 1'b0;
        dct_buffer     = '0;
        dct_count      = '0;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_ready       = 1'b0;
    endtask

    task automatic restart();
        quiet();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
    endtask

    task automatic write_word(input int d, input int c);
        dct_valid  = 1'b1;
        dct_buffer = DW'(d);
        dct_count  = CW'(c);
        tick();
        dct_valid  = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({rvalid[k], rdata[k], rcnt[k], lvl[k], st[k], dn[k]} !== '0
                || ovf_of(k) != 0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got v=%0b d=%h c=%0d l=%0d o=%0d s=%0d dn=%0b want all 0",
                         k, rvalid[k], rdata[k], rcnt[k], lvl[k], ovf_of(k), st[k], dn[k]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int dv [3] = '{1, 2, 3};
        int cv [3] = '{2, 1, 4};
        restart();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_word(dv[i], cv[i]);
            n_chk++;
            if (rvalid[0] !== 1'b1 || rdata[0] !== DW'(dv[i]) || rcnt[0] !== CW'(cv[i])) begin
                n_fail++;
                $display("FAIL basic_word%0d: got v=%0b d=%h c=%0d want v=1 d=%h c=%0d",
                         i, rvalid[0], rdata[0], rcnt[0], dv[i], cv[i]);
            end
            n_chk++;
            if (lvl[1] !== 5'd1 || rdata[1] !== DW'(dv[i])) begin
                n_fail++;
                $display("FAIL basic_wrap_word%0d: got l=%0d d=%h want l=1 d=%h",
                         i, lvl[1], rdata[1], dv[i]);
            end
        end
        tick();
        n_chk++;
        if (lvl[0] !== 5'd0 || rvalid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drained: got l=%0d v=%0b want l=0 v=0", lvl[0], rvalid[0]);
        end
    endtask

    task automatic test_overflow();
        restart();
        for (int i = 1; i <= 20; i++) write_word(i, (i % 15) + 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (lvl[k] !== 5'd16 || ovf_of(k) != 4) begin
                n_fail++;
                $display("FAIL overflow_full[%0d]: got l=%0d o=%0d want l=16 o=4",
                         k, lvl[k], ovf_of(k));
            end
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (rdata[0] !== DW'(i + 1) || rcnt[0] !== CW'(((i + 1) % 15) + 1)) begin
                n_fail++;
                $display("FAIL overflow_drop_drain%0d: got d=%h c=%0d want d=%h",
                         i, rdata[0], rcnt[0], i + 1);
            end
            n_chk++;
            if (rdata[1] !== DW'(i + 5) || rcnt[1] !== CW'(((i + 5) % 15) + 1)) begin
                n_fail++;
                $display("FAIL overflow_wrap_drain%0d: got d=%h c=%0d want d=%h",
                         i, rdata[1], rcnt[1], i + 5);
            end
            tick();
        end
        n_chk++;
        if (lvl[0] !== 5'd0 || lvl[1] !== 5'd0) begin
            n_fail++;
            $display("FAIL overflow_empty: got l0=%0d l1=%0d want 0", lvl[0], lvl[1]);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_ignored();
        quiet();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) write_word(32'h100 + i, 3);
        n_chk++;
        if (lvl[0] !== 5'd0 || ovf0 !== 16'd0 || st[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL ignored_idle: got l=%0d o=%0d s=%0d want 0 0 0", lvl[0], ovf0, st[0]);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) write_word(32'h200 + i, 0);
        n_chk++;
        if (lvl[0] !== 5'd0 || ovf0 !== 16'd0 || st[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL ignored_empty_pkt: got l=%0d o=%0d s=%0d want 0 0 1", lvl[0], ovf0, st[0]);
        end
    endtask

    task automatic test_flush();
        int pops;
        restart();
        for (int i = 0; i < 5; i++) write_word(32'h30 + i, 1 + i);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        tick();
        n_chk++;
        if (st[0] !== 2'd2 || dn[0] !== 1'b0 || lvl[0] !== 5'd5) begin
            n_fail++;
            $display("FAIL flush_hold: got s=%0d dn=%0b l=%0d want s=2 dn=0 l=5", st[0], dn[0], lvl[0]);
        end
        rd_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 30 && dn[0] !== 1'b1; c++) begin
            if (rvalid[0]) pops++;
            tick();
        end
        n_chk++;
        if (pops != 5 || st[0] !== 2'd3 || dn[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: got pops=%0d s=%0d dn=%0b want pops=5 s=3 dn=1",
                     pops, st[0], dn[0]);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        restart();
        for (int i = 1; i <= 16; i++) write_word(i, 2);
        rd_ready = 1'b1;
        write_word(99, 7);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (lvl[k] !== 5'd16 || ovf_of(k) != 0 || rdata[k] !== DW'(2)) begin
                n_fail++;
                $display("FAIL full_pop[%0d]: got l=%0d o=%0d d=%h want l=16 o=0 d=2",
                         k, lvl[k], ovf_of(k), rdata[k]);
            end
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rvalid[k] !== 1'b0 || lvl[k] !== 5'd0 || st[k] !== 2'd0) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: got v=%0b l=%0d s=%0d want 0 0 0",
                         k, rvalid[k], lvl[k], st[k]);
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_saturate();
        restart();
        for (int i = 1; i <= 28; i++) write_word(i, 5);
        n_chk++;
        if (ovf0 !== 16'd12 || ovf1 !== 3'd7) begin
            n_fail++;
            $display("FAIL saturate: got o0=%0d o1=%0d want 12 7", ovf0, ovf1);
        end
    endtask

    task automatic test_random();
        restart();
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            arm            = ($urandom_range(0, 19) == 0);
            dct_valid      = ($urandom_range(0, 1) == 1);
            dct_buffer     = DW'($urandom);
            dct_count      = ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom_range(1, 15));
            test_ending    = ($urandom_range(0, 39) == 0);
            test_has_ended = ($urandom_range(0, 59) == 0);
            rd_ready       = ($urandom_range(0, 2) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (rvalid[k] !== (q[k].size() > 0) || lvl[k] !== 5'(q[k].size())
                    || ovf_of(k) != ovf_m[k] || st[k] !== 2'(st_m[k])
                    || dn[k] !== (st_m[k] == 3)) begin
                    n_fail++;
                    $display("FAIL random_ctl[%0d] c%0d: got v=%0b l=%0d o=%0d s=%0d dn=%0b want l=%0d o=%0d s=%0d",
                             k, c, rvalid[k], lvl[k], ovf_of(k), st[k], dn[k],
                             q[k].size(), ovf_m[k], st_m[k]);
                end
                if (q[k].size() > 0) begin
                    n_chk++;
                    if ({rcnt[k], rdata[k]} !== q[k][0]) begin
                        n_fail++;
                        $display("FAIL random_data[%0d] c%0d: got %h want %h",
                                 k, c, {rcnt[k], rdata[k]}, q[k][0]);
                    end
                end
            end
        end
        quiet();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ignored();
        test_flush();
        test_full_pop();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
